// File: rtl/branch_sequencer.sv
// Program-counter sequencer: sequential issue, taken branches, CALL/RET through a
// return-address stack, stall hold, a one-cycle flush bubble per redirect, sticky stack faults.
module branch_sequencer #(
  parameter int unsigned     ADDR_W      = 16,
  parameter int unsigned     STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           is_branch,
  input  logic                           jump,
  input  logic                           is_call,
  input  logic                           is_ret,
  input  logic [ADDR_W-1:0]              target,
  output logic [ADDR_W-1:0]              pc,
  output logic                           issue_valid,
  output logic                           flush,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           fault,
  output logic [1:0]                     fault_code
);

  localparam int unsigned PW = $clog2(STACK_DEPTH);
  localparam int unsigned DW = PW + 1;
  localparam logic [DW-1:0] DepthMax = DW'(STACK_DEPTH);

  localparam logic [1:0] CodeNone      = 2'b00;
  localparam logic [1:0] CodeOverflow  = 2'b01;
  localparam logic [1:0] CodeUnderflow = 2'b10;

  typedef enum logic [1:0] {StRun, StFlush, StFault} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DW-1:0]       depth_q, depth_d;
  logic [1:0]          fault_code_q, fault_code_d;
  logic [ADDR_W-1:0]   stack_q [STACK_DEPTH];
  logic                push_en;
  logic [PW-1:0]       push_idx;
  logic [PW-1:0]       pop_idx;
  logic [DW-1:0]       depth_m1;
  logic [ADDR_W-1:0]   pc_inc;

  assign pc_inc   = pc_q + 1'b1;
  assign depth_m1 = depth_q - 1'b1;
  assign push_idx = depth_q[PW-1:0];
  assign pop_idx  = depth_m1[PW-1:0];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    depth_d      = depth_q;
    fault_code_d = fault_code_q;
    push_en      = 1'b0;
    unique case (state_q)
      StRun: begin
        if (!stall) begin
          if (is_ret) begin
            if (depth_q == '0) begin
              fault_code_d = CodeUnderflow;
              state_d      = StFault;
            end else begin
              pc_d    = stack_q[pop_idx];
              depth_d = depth_m1;
              state_d = StFlush;
            end
          end else if (is_call) begin
            if (depth_q == DepthMax) begin
              fault_code_d = CodeOverflow;
              state_d      = StFault;
            end else begin
              push_en = 1'b1;
              pc_d    = target;
              depth_d = depth_q + 1'b1;
              state_d = StFlush;
            end
          end else if (is_branch && jump) begin
            pc_d    = target;
            state_d = StFlush;
          end else begin
            pc_d = pc_inc;
          end
        end
      end
      // Bubble is exactly one cycle; stall does not extend it.
      StFlush: state_d = StRun;
      StFault: state_d = StFault;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      depth_q      <= '0;
      fault_code_q <= CodeNone;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      depth_q      <= depth_d;
      fault_code_q <= fault_code_d;
    end
  end

  // Stack contents are don't-care after reset, so no reset on the storage.
  always_ff @(posedge clk) begin
    if (!reset && push_en) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign issue_valid = (state_q == StRun);
  assign flush       = (state_q == StFlush);
  assign depth       = depth_q;
  assign fault       = (state_q == StFault);
  assign fault_code  = fault_code_q;

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Program-counter sequencer that consumes the 1-bit jump decision from the compare unit, together with decode flags and a target address, and produces the next instruction address. It handles taken/not-taken conditional branches, CALL/RET through an internal return-address stack, stall hold, and a one-cycle flush bubble after every redirect. It sits between instruction decode/compare and the instruction memory address port.

Parameters:
ADDR_W, 16, width of pc, target and stack entries
STACK_DEPTH, 8, return-address stack entries (power of 2, >=2)
RESET_PC, 16'h0000, pc value after reset

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold all state this cycle (ignored in FLUSH and FAULT)
is_branch  in  1  current instruction is a conditional jump
jump  in  1  branch condition result from the compare unit; meaningful only with is_branch
is_call  in  1  current instruction is CALL (unconditional; pushes return address)
is_ret  in  1  current instruction is RET (pops return address)
target  in  ADDR_W  branch/call target address
pc  out  ADDR_W  address of the instruction currently issued
issue_valid  out  1  pc holds a valid instruction to execute
flush  out  1  one-cycle pulse: discard instruction fetched at old pc
depth  out  log2(STACK_DEPTH)+1  current stack occupancy, 0..STACK_DEPTH
fault  out  1  sticky; set on stack overflow or underflow
fault_code  out  2  00 none, 01 overflow, 10 underflow; sticky with fault

Behaviour:
- Reset (sync, highest priority, any state including mid-flush): pc=RESET_PC, issue_valid=1, flush=0, depth=0, fault=0, fault_code=00, state=RUN. Stack contents are don't-care.
- States: RUN, FLUSH, FAULT.
- Control inputs are sampled on a clock edge only in RUN with stall=0 and issue_valid=1.
- Priority when sampled: is_ret > is_call > is_branch > sequential. Multiple flags asserted together are illegal but resolved by this priority.
- RUN, stall=1: pc, depth, stack and state hold; flush=0.
- RUN, sequential (no flag, or is_branch with jump=0): pc <= pc+1, wrapping modulo 2^ADDR_W (all-ones -> 0). No flush.
- RUN, is_branch and jump=1: pc <= target, flush=1 next cycle, go to FLUSH.
- RUN, is_call with depth<STACK_DEPTH:
  - push pc+1 (wrapped) at stack[depth], depth <= depth+1.
  - pc <= target, flush=1, go to FLUSH.
- RUN, is_call with depth==STACK_DEPTH:
  - no push, pc holds.
  - fault=1, fault_code=01, issue_valid=0, go to FAULT.
- RUN, is_ret with depth>0: pc <= stack[depth-1], depth <= depth-1, flush=1, go to FLUSH.
- RUN, is_ret with depth==0:
  - pc holds.
  - fault=1, fault_code=10, issue_valid=0, go to FAULT.
- FLUSH:
  - Lasts exactly one cycle, regardless of stall.
  - issue_valid=0, flush=1, pc holds the redirect address.
  - Next cycle: RUN, issue_valid=1, flush=0.
- FAULT: pc, depth and stack frozen; issue_valid=0, flush=0. Exited only by reset.
- Latency:
  - Sequential: next instruction issues 1 cycle later.
  - Taken branch, CALL or RET: target issues 2 cycles after the sampling edge (1 bubble).
- target is used only on a taken branch or CALL; it is ignored otherwise.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset then 4 idle cycles -> pc 0,1,2,3, issue_valid=1, flush=0 throughout.
- At pc=5: is_branch=1, jump=0, target=16'h0040 -> pc=6, no flush. Then is_branch=1, jump=1, target=16'h0040 -> next cycle flush=1, issue_valid=0; following cycle pc=16'h0040, issue_valid=1.
- At pc=16'h0010: is_call, target=16'h0100 -> depth=1, pc=16'h0100 after bubble. At pc=16'h0102: is_ret -> pc=16'h0011 after bubble, depth=0.
- STACK_DEPTH=8: nine nested calls -> first eight push (depth=8). Ninth -> fault=1, fault_code=01, issue_valid=0, pc frozen. Then reset -> all cleared, pc=RESET_PC.
- From reset, is_ret -> fault=1, fault_code=10. Separately, pc=16'hFFFF sequential -> pc=16'h0000 wrap.
- Stall held 3 cycles at pc=7 with is_branch/jump=1 -> pc stays 7, no flush; on release, redirect proceeds. Assert stall during FLUSH -> bubble still ends after one cycle. Reset asserted during FLUSH -> pc=RESET_PC, flush=0 next cycle.
